// File: rtl/nsr_accum_sequencer_if.sv
// Bus between the control unit / vector register files and the neuron-state sequencer.
// master = control side (drives start, operands, register read data); slave = sequencer.
interface nsr_accum_sequencer_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 4
);
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic              start;
    logic              sor_nacc;
    logic              nacc_vl;
    logic [1:0]        vl_cfg;
    logic [DATA_W-1:0] threshold;
    logic [IDX_W-1:0]  elem_idx;
    logic [DATA_W-1:0] wvr_elem;
    logic              svr_bit;
    logic [DATA_W-1:0] nsr_rdata;
    logic              nsr_we;
    logic [DATA_W-1:0] nsr_wdata;
    logic              spike_o;
    logic              stall_o;
    logic              done_o;

    modport master (
        output start, sor_nacc, nacc_vl, vl_cfg, threshold,
        output wvr_elem, svr_bit, nsr_rdata,
        input  elem_idx, nsr_we, nsr_wdata, spike_o, stall_o, done_o
    );

    modport slave (
        input  start, sor_nacc, nacc_vl, vl_cfg, threshold,
        input  wvr_elem, svr_bit, nsr_rdata,
        output elem_idx, nsr_we, nsr_wdata, spike_o, stall_o, done_o
    );
endinterface

// File: rtl/nsr_accum_sequencer.sv
// Neuron-state sequencer: LOAD NSR, then NACC accumulate or spike-evaluate, then WRITE NSR.
// Define NACC_SAT_EN to make the NACC addition saturate instead of wrapping.
module nsr_accum_sequencer #(
    parameter int DATA_W     = 32,
    parameter int NUM_LANES  = 4,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nsr_accum_sequencer_if.slave  bus
);
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACC,
        S_EVAL,
        S_WRITE
    } state_e;

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0]  thr_q, thr_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          n_last_q, n_last_d;
    logic                      op_nacc_q, op_nacc_d;
    logic                      fire_q, fire_d;

    logic signed [DATA_W-1:0]  acc_add;
    logic signed [DATA_W-1:0]  acc_leak;
    logic [IDX_W-1:0]          n_last_start;

    // Element count minus one, so the ACC exit test is a plain compare against cnt.
    always_comb begin
        n_last_start = '0;
        if (bus.nacc_vl) begin
            case (bus.vl_cfg)
                2'b00:   n_last_start = '0;
                2'b01:   n_last_start = IDX_W'(1);
                default: n_last_start = IDX_W'(NUM_LANES - 1);
            endcase
        end
    end

`ifdef NACC_SAT_EN
    logic signed [DATA_W:0] sum_ext;

    // One guard bit: the top two bits differ exactly when the DATA_W result overflowed.
    always_comb begin
        sum_ext = {acc_q[DATA_W-1], acc_q} + {bus.wvr_elem[DATA_W-1], bus.wvr_elem};
        acc_add = sum_ext[DATA_W-1:0];
        if (sum_ext[DATA_W] != sum_ext[DATA_W-1])
            acc_add = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    always_comb begin
        acc_add = acc_q + $signed(bus.wvr_elem);
    end
`endif

    assign acc_leak = acc_q - (acc_q >>> LEAK_SHIFT);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        thr_d     = thr_q;
        cnt_d     = cnt_q;
        n_last_d  = n_last_q;
        op_nacc_d = op_nacc_q;
        fire_d    = fire_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_nacc_d = bus.sor_nacc;
                    n_last_d  = n_last_start;
                    thr_d     = $signed(bus.threshold);
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_d   = $signed(bus.nsr_rdata);
                cnt_d   = '0;
                fire_d  = 1'b0;
                state_d = op_nacc_q ? S_ACC : S_EVAL;
            end
            S_ACC: begin
                if (bus.svr_bit)
                    acc_d = acc_add;
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == n_last_q)
                    state_d = S_WRITE;
            end
            S_EVAL: begin
                if (acc_q >= thr_q) begin
                    fire_d = 1'b1;
                    acc_d  = '0;
                end else begin
                    fire_d = 1'b0;
                    acc_d  = acc_leak;
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            thr_q     <= '0;
            cnt_q     <= '0;
            n_last_q  <= '0;
            op_nacc_q <= 1'b0;
            fire_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            thr_q     <= thr_d;
            cnt_q     <= cnt_d;
            n_last_q  <= n_last_d;
            op_nacc_q <= op_nacc_d;
            fire_q    <= fire_d;
        end
    end

    logic in_write;
    assign in_write      = (state_q == S_WRITE);
    assign bus.elem_idx  = (state_q == S_ACC) ? cnt_q : '0;
    assign bus.nsr_we    = in_write;
    assign bus.done_o    = in_write;
    assign bus.spike_o   = in_write & fire_q;
    assign bus.nsr_wdata = in_write ? acc_q : '0;
    assign bus.stall_o   = bus.start | (state_q != S_IDLE);

endmodule

// File: tb/tb_nsr_accum_sequencer.sv
// Directed bench for nsr_accum_sequencer: reset, NACC, evaluate, overflow, abort, re-start.
// Expected values are hand-computed from the operation definitions.
module tb_nsr_accum_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    nsr_accum_sequencer_if #(.DATA_W(32), .NUM_LANES(4)) ifc ();

    nsr_accum_sequencer #(.DATA_W(32), .NUM_LANES(4), .LEAK_SHIFT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    logic [31:0] w_arr [4];
    logic [3:0]  svr;
    logic [31:0] nsr_val;

    assign ifc.wvr_elem  = w_arr[ifc.elem_idx];
    assign ifc.svr_bit   = svr[ifc.elem_idx];
    assign ifc.nsr_rdata = nsr_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launch one op at the current negedge, follow it to WRITE, check the writeback and stall drop.
    // Operand inputs are flipped after the start cycle to prove they were latched.
    task automatic run_op(input string tag, input logic op, input logic vl, input logic [1:0] cfg,
                          input logic [31:0] thr, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_spk);
        int cyc;
        ifc.start = 1'b1; ifc.sor_nacc = op; ifc.nacc_vl = vl;
        ifc.vl_cfg = cfg; ifc.threshold = thr;
        #1 chk({tag, "_stall_c0"}, 32'(ifc.stall_o), 32'd1);
        step();
        ifc.start = 1'b0; ifc.sor_nacc = ~op; ifc.nacc_vl = ~vl;
        ifc.vl_cfg = ~cfg; ifc.threshold = ~thr;
        cyc = 1;
        while (cyc < 20) begin
            #1;
            if (ifc.nsr_we) break;
            chk({tag, "_stall_busy"}, 32'(ifc.stall_o), 32'd1);
            if (op && cyc >= 2) chk({tag, "_elem_idx"}, 32'(ifc.elem_idx), 32'(cyc - 2));
            step();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_wdata"}, ifc.nsr_wdata, exp_data);
        chk({tag, "_spike"}, 32'(ifc.spike_o), 32'(exp_spk));
        chk({tag, "_done"}, 32'(ifc.done_o), 32'd1);
        chk({tag, "_stall_write"}, 32'(ifc.stall_o), 32'd1);
        step();
        #1 chk({tag, "_stall_after"}, 32'(ifc.stall_o), 32'd0);
        chk({tag, "_we_after"}, 32'(ifc.nsr_we), 32'd0);
    endtask

    initial begin
        int we_cnt;
        logic [31:0] wr_data;
        ifc.start = 1'b0; ifc.sor_nacc = 1'b0; ifc.nacc_vl = 1'b0;
        ifc.vl_cfg = 2'b00; ifc.threshold = '0;
        w_arr[0] = 32'd5; w_arr[1] = 32'd7; w_arr[2] = -32'sd3; w_arr[3] = 32'd10;
        svr = 4'b1011;
        nsr_val = 32'd100;

        // 1. reset, then a reset pulse while idle
        repeat (2) step();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(ifc.nsr_we), 32'd0);
        chk("rst_spike", 32'(ifc.spike_o), 32'd0);
        chk("rst_done", 32'(ifc.done_o), 32'd0);
        chk("rst_stall", 32'(ifc.stall_o), 32'd0);
        chk("rst_elem", 32'(ifc.elem_idx), 32'd0);
        chk("rst_wdata", ifc.nsr_wdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 2. NACC over 4 elements: 100 + 5 + 7 + 10 (element 2 has no spike)
        run_op("nacc4", 1'b1, 1'b1, 2'b10, 32'd0, 6, 32'd122, 1'b0);
        // two elements with vl_cfg=01: 0 + 5 + 7
        nsr_val = 32'd0;
        run_op("nacc2", 1'b1, 1'b1, 2'b01, 32'd0, 4, 32'd12, 1'b0);

        // 3. spike-evaluate; back-to-back launches exercise restart right after WRITE
        nsr_val = 32'd200;
        run_op("eval_fire", 1'b0, 1'b0, 2'b00, 32'd150, 3, 32'd0, 1'b1);
        nsr_val = 32'd100;
        run_op("eval_leak", 1'b0, 1'b0, 2'b00, 32'd150, 3, 32'd94, 1'b0);
        nsr_val = 32'd150;
        run_op("eval_equal", 1'b0, 1'b0, 2'b00, 32'd150, 3, 32'd0, 1'b1);
        nsr_val = -32'sd100;
        run_op("eval_neg", 1'b0, 1'b0, 2'b00, 32'd150, 3, -32'sd93, 1'b0);

        // 4. overflow on a single-element NACC (nacc_vl=0 ignores vl_cfg)
        nsr_val = 32'h7FFF_FFF0;
        w_arr[0] = 32'h0000_0100;
`ifdef NACC_SAT_EN
        run_op("nacc_ovf", 1'b1, 1'b0, 2'b10, 32'd0, 3, 32'h7FFF_FFFF, 1'b0);
`else
        run_op("nacc_ovf", 1'b1, 1'b0, 2'b10, 32'd0, 3, 32'h8000_00F0, 1'b0);
`endif
        w_arr[0] = 32'd5;
        nsr_val = 32'd100;

        // 5. reset asserted during the second ACC cycle aborts the op
        ifc.start = 1'b1; ifc.sor_nacc = 1'b1; ifc.nacc_vl = 1'b1; ifc.vl_cfg = 2'b10;
        step();
        ifc.start = 1'b0;
        step();
        step();
        #1 chk("abort_pre_elem", 32'(ifc.elem_idx), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", 32'(ifc.stall_o), 32'd0);
        chk("abort_elem", 32'(ifc.elem_idx), 32'd0);
        we_cnt = 0;
        repeat (4) begin
            step();
            #1 if (ifc.nsr_we || ifc.spike_o) we_cnt++;
        end
        chk("abort_no_we", 32'(we_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort_idle_stall", 32'(ifc.stall_o), 32'd0);
        @(negedge clk);
        run_op("post_abort", 1'b1, 1'b1, 2'b10, 32'd0, 6, 32'd122, 1'b0);

        // 6. start re-pulsed during ACC is ignored: exactly one WRITE
        ifc.start = 1'b1; ifc.sor_nacc = 1'b1; ifc.nacc_vl = 1'b1; ifc.vl_cfg = 2'b10;
        step();
        ifc.start = 1'b0;
        step();
        step();
        ifc.start = 1'b1; ifc.sor_nacc = 1'b0;
        step();
        ifc.start = 1'b0;
        we_cnt = 0;
        wr_data = '0;
        repeat (8) begin
            #1 if (ifc.nsr_we) begin
                we_cnt++;
                wr_data = ifc.nsr_wdata;
            end
            step();
        end
        chk("restart_we_count", 32'(we_cnt), 32'd1);
        chk("restart_wdata", wr_data, 32'd122);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
